// File: rtl/core_mem_port_arb_pkg.sv
// Shared types and constants for the core memory-port arbiter.
//   src_e            : identifies which core interface issued a transaction
//   INSTR_BE         : byte enable driven for every instruction fetch
//   MAX_OUTSTANDING  : largest supported ID FIFO depth
package core_mem_port_arb_pkg;

  typedef enum logic {SRC_INSTR, SRC_DATA} src_e;

  localparam logic [3:0] INSTR_BE        = 4'hF;
  localparam int         MAX_OUTSTANDING = 8;

endpackage

// File: rtl/core_mem_port_arb_id_fifo.sv
// In-order FIFO of transaction sources. Each granted transaction pushes its
// source here; each memory response pops the head to find its owner.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/src_i : enqueue src_i (ignored when full)
//   pop_i        : dequeue the head (ignored when empty)
//   head_o       : oldest stored source
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
//   count_o      : number of entries stored
module core_mem_port_arb_id_fifo
  import core_mem_port_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  src_e          src_i,
  input  logic          pop_i,
  output src_e          head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  // One pointer bit minimum so a depth-1 FIFO still has a legal index.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  src_e          mem_q [2**PW];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Pointers wrap at DEPTH, which need not be a power of two.
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= src_i;
  end

endmodule

// File: rtl/core_mem_port_arbiter.sv
// Shares one OBI memory port between the instruction-fetch and data
// interfaces of the core. Address phases are arbitrated round-robin and the
// choice is held until the memory grants it; the owner of every granted
// transaction is queued so responses return to the right requester.
//
// Build option: CORE_MEM_PORT_ARB_DATA_PRIO_EN -- when defined, unlocked
// ties always go to DATA (fixed priority) instead of round-robin.
//
// Ports:
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   instr_* (req/gnt/rvalid/addr/rdata)           : fetch interface
//   data_*  (req/gnt/rvalid/we/be/addr/wdata/rdata): data interface
//   mem_*   (req/gnt/rvalid/we/be/addr/wdata/rdata): shared memory port
//   outstanding_o            : granted transactions awaiting a response
//   protocol_err_o           : sticky; a response arrived with nothing pending
//
// Handshake: an address phase transfers on a cycle where req and gnt are both
// high; the requester holds req and its address phase stable until then. A
// response is one cycle with rvalid high, no earlier than the cycle after the
// grant, in the same order the grants were given.
module core_mem_port_arbiter
  import core_mem_port_arb_pkg::*;
#(
  parameter int NUM_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 instr_req_i,
  output logic                                 instr_gnt_o,
  output logic                                 instr_rvalid_o,
  input  logic [31:0]                          instr_addr_i,
  output logic [31:0]                          instr_rdata_o,
  input  logic                                 data_req_i,
  output logic                                 data_gnt_o,
  output logic                                 data_rvalid_o,
  input  logic                                 data_we_i,
  input  logic [3:0]                           data_be_i,
  input  logic [31:0]                          data_addr_i,
  input  logic [31:0]                          data_wdata_i,
  output logic [31:0]                          data_rdata_o,
  output logic                                 mem_req_o,
  input  logic                                 mem_gnt_i,
  input  logic                                 mem_rvalid_i,
  output logic                                 mem_we_o,
  output logic [3:0]                           mem_be_o,
  output logic [31:0]                          mem_addr_o,
  output logic [31:0]                          mem_wdata_o,
  input  logic [31:0]                          mem_rdata_i,
  output logic [$clog2(NUM_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 protocol_err_o
);

  localparam int CW = $clog2(NUM_OUTSTANDING + 1);

  logic locked_q, locked_d;
  src_e sel_q, sel_d;
  logic perr_q, perr_d;
`ifndef CORE_MEM_PORT_ARB_DATA_PRIO_EN
  src_e last_q, last_d;
`endif

  src_e          arb_sel, sel;
  logic          sel_req;
  logic          push, pop;
  src_e          head;
  logic          full, empty;
  logic [CW-1:0] count;

  // Fresh arbitration, only used while no selection is locked.
  always_comb begin
    arb_sel = SRC_INSTR;
    if (instr_req_i && data_req_i) begin
`ifdef CORE_MEM_PORT_ARB_DATA_PRIO_EN
      arb_sel = SRC_DATA;
`else
      arb_sel = (last_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
`endif
    end else if (data_req_i) begin
      arb_sel = SRC_DATA;
    end
  end

  assign sel     = locked_q ? sel_q : arb_sel;
  assign sel_req = (sel == SRC_INSTR) ? instr_req_i : data_req_i;

  // Held off while full even if a response frees a slot this cycle, so the
  // request never depends combinationally on mem_rvalid_i.
  assign mem_req_o   = sel_req && !full;
  assign mem_addr_o  = (sel == SRC_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = (sel == SRC_DATA) ? data_we_i    : 1'b0;
  assign mem_be_o    = (sel == SRC_DATA) ? data_be_i    : INSTR_BE;
  assign mem_wdata_o = (sel == SRC_DATA) ? data_wdata_i : 32'h0;

  assign push = mem_req_o && mem_gnt_i;
  assign pop  = mem_rvalid_i;

  assign instr_gnt_o = push && (sel == SRC_INSTR);
  assign data_gnt_o  = push && (sel == SRC_DATA);

  assign instr_rvalid_o = mem_rvalid_i && !empty && (head == SRC_INSTR);
  assign data_rvalid_o  = mem_rvalid_i && !empty && (head == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign outstanding_o  = count;
  assign protocol_err_o = perr_q;

  always_comb begin
    locked_d = locked_q;
    sel_d    = sel_q;
    perr_d   = perr_q || (mem_rvalid_i && empty);
`ifndef CORE_MEM_PORT_ARB_DATA_PRIO_EN
    last_d   = push ? sel : last_q;
`endif
    if (mem_gnt_i) begin
      locked_d = 1'b0;
    end else if (mem_req_o) begin
      locked_d = 1'b1;
      sel_d    = sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_q <= 1'b0;
      sel_q    <= SRC_INSTR;
      perr_q   <= 1'b0;
`ifndef CORE_MEM_PORT_ARB_DATA_PRIO_EN
      last_q   <= SRC_DATA;
`endif
    end else begin
      locked_q <= locked_d;
      sel_q    <= sel_d;
      perr_q   <= perr_d;
`ifndef CORE_MEM_PORT_ARB_DATA_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  core_mem_port_arb_id_fifo #(
    .DEPTH (NUM_OUTSTANDING),
    .CW    (CW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .src_i   (sel),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule
